// File: rtl/pulse_width_meter_pkg.sv
// Shared types and helpers for the pulse width meter.
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // All-ones value of a w-bit saturating counter (w < 32).
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_meter_out_reg.sv
// Single-entry record holder: valid/ready output, a new record replaces
// the old one on the accept cycle, otherwise a blocked record is dropped
// and counted in a saturating counter.
module pulse_width_meter_out_reg
  import pulse_width_meter_pkg::*;
#(
  parameter int RecW      = 18,
  parameter int DropWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic [RecW-1:0]      in_rec_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [RecW-1:0]      out_rec_o,
  output logic [DropWidth-1:0] drop_cnt_o
);

  localparam logic [DropWidth-1:0] MaxDrop = DropWidth'(sat_max(DropWidth));
  localparam logic [DropWidth-1:0] DropOne = DropWidth'(1);

  logic accept;
  assign accept = out_valid_o & out_ready_i;

  // Hold/replace/drop the single output record.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      out_valid_o <= 1'b0;
      out_rec_o   <= '0;
      drop_cnt_o  <= '0;
    end else if (in_valid_i) begin
      if (!out_valid_o || accept) begin
        out_valid_o <= 1'b1;
        out_rec_o   <= in_rec_i;
      end else if (drop_cnt_o != MaxDrop) begin
        drop_cnt_o  <= drop_cnt_o + DropOne;
      end
    end else if (accept) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Pulse width meter: measures high/low pulse widths in en_i samples from
// upstream edge strobes and emits one record per completed pulse.
// Optional macro PULSE_WIDTH_METER_TIMEOUT_EN: a pulse reaching the max
// width is reported once (sat=1) and the FSM returns to IDLE.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int CntWidth  = 16,
  parameter int DropWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 r_edge_i,
  input  logic                 f_edge_i,
  output logic                 meas_valid_o,
  input  logic                 meas_ready_i,
  output logic [CntWidth-1:0]  meas_width_o,
  output logic                 meas_level_o,
  output logic                 meas_sat_o,
  output logic                 proto_err_o,
  output logic [DropWidth-1:0] drop_cnt_o
);

  typedef struct packed {
    logic                sat;
    logic                level;
    logic [CntWidth-1:0] width;
  } rec_t;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(sat_max(CntWidth));
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rec_vld;
  rec_t                rec, rec_out;
  rec_t                edge_rec;

  // Record content if the pulse closes at this edge: width = cnt+1, saturated.
  always_comb begin
    edge_rec       = '0;
    edge_rec.sat   = (cnt_q == MaxCnt);
    edge_rec.level = (state_q == HIGH);
    edge_rec.width = (cnt_q == MaxCnt) ? MaxCnt : cnt_q + CntOne;
  end

  // Next-state, counter and record generation; nothing moves without en_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rec_vld = 1'b0;
    rec     = edge_rec;
    if (en_i) begin
      if (r_edge_i && f_edge_i) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else if (r_edge_i || f_edge_i) begin
        cnt_d = '0;
        unique case (state_q)
          IDLE: state_d = r_edge_i ? HIGH : LOW;
          HIGH: begin
            if (f_edge_i) begin
              rec_vld = 1'b1;
              state_d = LOW;
            end else begin
              err_d = 1'b1;
            end
          end
          LOW: begin
            if (r_edge_i) begin
              rec_vld = 1'b1;
              state_d = HIGH;
            end else begin
              err_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end else if (state_q != IDLE) begin
`ifdef PULSE_WIDTH_METER_TIMEOUT_EN
        if (cnt_q == MaxCnt - CntOne) begin
          // Stuck line: report once at max width, then wait for a fresh edge.
          rec_vld   = 1'b1;
          rec.sat   = 1'b1;
          rec.width = MaxCnt;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`else
        if (cnt_q != MaxCnt) cnt_d = cnt_q + CntOne;
`endif
      end
    end
  end

  // FSM, counter and error pulse registers; clear behaves like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  pulse_width_meter_out_reg #(
    .RecW      ($bits(rec_t)),
    .DropWidth (DropWidth)
  ) u_out_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (rec_vld),
    .in_rec_i    (rec),
    .out_valid_o (meas_valid_o),
    .out_ready_i (meas_ready_i),
    .out_rec_o   (rec_out),
    .drop_cnt_o  (drop_cnt_o)
  );

  assign meas_width_o = rec_out.width;
  assign meas_level_o = rec_out.level;
  assign meas_sat_o   = rec_out.sat;
  assign proto_err_o  = err_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter: scoreboard queues of expected
// records, compared whenever a record is handed over (valid & ready).
module tb_pulse_width_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clear = 1'b0, r_edge = 1'b0, f_edge = 1'b0, ready = 1'b1;
  logic sat_mode = 1'b0;
  logic en_m, en_s;

  logic        vld_m, lvl_m, sat_m, err_m;
  logic [15:0] wid_m;
  logic [7:0]  drop_m;
  logic        vld_s, lvl_s, sat_s, err_s;
  logic [3:0]  wid_s;
  logic [7:0]  drop_s;

  int n_chk = 0, n_fail = 0;
  logic [31:0] q_m[$];
  logic [31:0] q_s[$];

  assign en_m = en & ~sat_mode;
  assign en_s = en & sat_mode;

  always #5 clk = ~clk;

  pulse_width_meter #(.CntWidth(16), .DropWidth(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_m), .clear_i(clear),
    .r_edge_i(r_edge), .f_edge_i(f_edge),
    .meas_valid_o(vld_m), .meas_ready_i(ready), .meas_width_o(wid_m),
    .meas_level_o(lvl_m), .meas_sat_o(sat_m), .proto_err_o(err_m),
    .drop_cnt_o(drop_m)
  );

  pulse_width_meter #(.CntWidth(4), .DropWidth(8)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_s), .clear_i(clear),
    .r_edge_i(r_edge), .f_edge_i(f_edge),
    .meas_valid_o(vld_s), .meas_ready_i(ready), .meas_width_o(wid_s),
    .meas_level_o(lvl_s), .meas_sat_o(sat_s), .proto_err_o(err_s),
    .drop_cnt_o(drop_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit s, input bit l, input int w);
    return (32'(s) << 17) | (32'(l) << 16) | 32'(w);
  endfunction

  // Score every handed-over record against the head of its queue.
  always @(negedge clk) begin
    if (vld_m && ready) begin
      if (q_m.size() == 0) chk("unexp_rec_m", mk(sat_m, lvl_m, int'(wid_m)), 32'hFFFF_FFFF);
      else chk("rec_m", mk(sat_m, lvl_m, int'(wid_m)), q_m.pop_front());
    end
    if (vld_s && ready) begin
      if (q_s.size() == 0) chk("unexp_rec_s", mk(sat_s, lvl_s, int'(wid_s)), 32'hFFFF_FFFF);
      else chk("rec_s", mk(sat_s, lvl_s, int'(wid_s)), q_s.pop_front());
    end
  end

  // One sample slot: inputs consumed at the next posedge, outputs settle by +#1.
  task automatic drive(input logic e, input logic r, input logic f);
    en = e; r_edge = r; f_edge = f;
    @(posedge clk); #1;
    en = 1'b1; r_edge = 1'b0; f_edge = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("rst_valid", 32'(vld_m), 32'd0);
    chk("rst_width", 32'(wid_m), 32'd0);
    chk("rst_err", 32'(err_m), 32'd0);
    chk("rst_drop", 32'(drop_m), 32'd0);
    rst_n = 1'b1;

    // Basic pulses: f aligns, r at t4, f at t9, r right after (replace on accept)
    drive(1'b1, 1'b0, 1'b1);
    chk("align_novalid", 32'(vld_m), 32'd0);
    idle(3);
    q_m.push_back(mk(0, 0, 4));
    drive(1'b1, 1'b1, 1'b0);
    chk("latency_valid", 32'(vld_m), 32'd1);
    idle(4);
    q_m.push_back(mk(0, 1, 5));
    drive(1'b1, 1'b0, 1'b1);
    q_m.push_back(mk(0, 0, 1));
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    chk("basic_drop", 32'(drop_m), 32'd0);
    chk("basic_valid_idle", 32'(vld_m), 32'd0);

    // Back-pressure: first record held, two later ones dropped
    do_clear();
    ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    idle(2);
    q_m.push_back(mk(0, 0, 3));
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 1'b1);
    chk("bp_hold_w", 32'(wid_m), 32'd3);
    chk("bp_hold_l", 32'(lvl_m), 32'd0);
    chk("bp_drop1", 32'(drop_m), 32'd1);
    idle(2);
    drive(1'b1, 1'b1, 1'b0);
    chk("bp_hold_v", 32'(vld_m), 32'd1);
    chk("bp_hold_w2", 32'(wid_m), 32'd3);
    chk("bp_drop2", 32'(drop_m), 32'd2);
    ready = 1'b1;
    idle(1);
    chk("bp_accept_v", 32'(vld_m), 32'd0);

    // Protocol errors
    do_clear();
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0);
    chk("err_rr", 32'(err_m), 32'd1);
    chk("err_rr_norec", 32'(vld_m), 32'd0);
    idle(1);
    chk("err_pulse_end", 32'(err_m), 32'd0);
    idle(2);
    q_m.push_back(mk(0, 1, 4));
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 1'b1, 1'b1);
    chk("err_rf", 32'(err_m), 32'd1);
    idle(2);
    drive(1'b1, 1'b1, 1'b0);
    chk("rf_idle_align", 32'(vld_m), 32'd0);
    idle(1);
    q_m.push_back(mk(0, 1, 2));
    drive(1'b1, 1'b0, 1'b1);
    idle(2);

    // en_i gating: edges only on disabled samples are ignored
    do_clear();
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, i[0]);
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("gate_novalid", 32'(vld_m), 32'd0);
    q_m.push_back(mk(0, 0, 7));
    drive(1'b1, 1'b1, 1'b0);
    idle(2);

    // Saturation on the 4-bit instance: 20-sample high pulse
    do_clear();
    sat_mode = 1'b1;
    q_s.push_back(mk(1, 1, 15));
    drive(1'b1, 1'b1, 1'b0);
    idle(19);
    drive(1'b1, 1'b0, 1'b1);
    idle(2);
`ifdef PULSE_WIDTH_METER_TIMEOUT_EN
    chk("sat_to_align", 32'(vld_s), 32'd0);
`else
    chk("sat_drop", 32'(drop_s), 32'd0);
`endif
    sat_mode = 1'b0;

    // Clear then reset mid-pulse with a pending record
    do_clear();
    ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("clr_pre_valid", 32'(vld_m), 32'd1);
    chk("clr_pre_drop", 32'(drop_m), 32'd1);
    clear = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    chk("clr_valid", 32'(vld_m), 32'd0);
    chk("clr_drop", 32'(drop_m), 32'd0);
    chk("clr_err", 32'(err_m), 32'd0);
    ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    chk("clr_first_edge", 32'(vld_m), 32'd0);
    idle(1);
    q_m.push_back(mk(0, 1, 2));
    drive(1'b1, 1'b0, 1'b1);
    idle(2);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("rst_mid_valid", 32'(vld_m), 32'd0);
    chk("rst_mid_drop", 32'(drop_m), 32'd0);
    drive(1'b1, 1'b0, 1'b1);
    chk("rst_first_edge", 32'(vld_m), 32'd0);
    idle(1);
    q_m.push_back(mk(0, 0, 2));
    drive(1'b1, 1'b1, 1'b0);
    idle(3);

    chk("q_m_empty", 32'(q_m.size()), 32'd0);
    chk("q_s_empty", 32'(q_s.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
